nn_layer_sequencer: RTL and testbench
=====================================

# nn_layer_sequencer

Control FSM that runs one full MNIST inference through the three fully-connected layers, using the fixed start addresses in the `BRAM_ADDRS` package. It drives one shared read address to the per-neuron weight BRAMs and the layer-IO BRAM in lockstep, and times the MAC enables against BRAM read latency. It also sequences serial write-back of neuron results into the IO BRAM. It sits between the top-level inference control (start/done) and the neuron MAC array / BRAM ports.

## Interface
- `ADDR_W`, 10, BRAM address width.
- `N_HID`, 20, neurons in layers 1 and 2.
- `N_OUT`, 10, neurons in layer 3.
- `BRAM_LAT`, 1, BRAM read latency in cycles (1..3).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `rd_addr`  out  ADDR_W  shared read address (weight BRAMs and IO BRAM).
- `mac_clr`  out  1  clear all neuron accumulators.
- `mac_en`  out  1  accumulate weight × IO data presented this cycle.
- `bias_en`  out  1  accumulate weight word as bias; ignore IO data.
- `relu_en`  out  1  apply ReLU on write-back. High for layers 1 and 2, low for layer 3.
- `wr_addr`  out  ADDR_W  IO BRAM write address.
- `wr_sel`  out  5  neuron index muxed onto IO BRAM write data.
- `io_we`  out  1  IO BRAM write enable.
- `layer`  out  2  active layer: 0 idle, 1..3.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse at end of inference.

## Operation
- Per-layer constants:
  - L1: inputs at `WEIGHT_1` through `BIAS_1`-1 (784 entries), bias at `BIAS_1`, outputs to `LAYER_IO_1`, N=`N_HID`.
  - L2: `WEIGHT_2`..`BIAS_2`-1 (20), bias `BIAS_2`, outputs to `LAYER_IO_2`, N=`N_HID`.
  - L3: `WEIGHT_3`..`BIAS_3`-1 (20), bias `BIAS_3`, outputs to `LAYER_IO_3`, N=`N_OUT`.
- Weight and IO input addresses are identical for every layer (`WEIGHT_k` equals the previous layer's IO base), so a single `rd_addr` is used.
- States: IDLE → MAC → BIAS → DRAIN → WB → (next layer MAC | DONE) → IDLE.
- IDLE:
  - All outputs 0.
  - `start`=1 → MAC with layer=1 and `rd_addr`=`WEIGHT_1`.
- MAC:
  - `rd_addr` increments by 1 each cycle.
  - The last cycle presents `BIAS_k`-1, then the FSM moves to BIAS.
  - `mac_clr`=1 only in the first MAC cycle of each layer.
- BIAS: `rd_addr`=`BIAS_k` for one cycle → DRAIN.
- DRAIN: `BRAM_LAT` cycles with no new addresses; `rd_addr` holds `BIAS_k` → WB.
- WB:
  - Runs N cycles, n=0..N-1.
  - Each cycle: `io_we`=1, `wr_sel`=n, `wr_addr`=`LAYER_IO_k`+n.
  - After n=N-1, go to MAC of layer k+1, or DONE if k=3.
- DONE: `done`=1, `busy`=0, `layer`=0 for one cycle → IDLE.
- `mac_en` / `bias_en` are the MAC-state / BIAS-state flags delayed `BRAM_LAT` cycles through a shift register, so each aligns with the returned data for its address.
- `wr_sel` width is sufficient for `N_HID`-1. Address adds are ADDR_W wide with no wrap; all used addresses are ≤ 0x344.
- `start` while busy is ignored; no queueing.
- `reset_n` low at any time: asynchronously forces IDLE, clears the delay pipeline, all outputs 0. In-flight accumulation is abandoned.

## Timing
- All outputs are registered; reset value of every output is 0.
- `start` sampled at edge 0 → at edge 1: `busy`=1, `layer`=1, `rd_addr`=0, `mac_clr`=1.
- First `mac_en` appears at edge 1+`BRAM_LAT`.
- Per-layer cycles = inputs + 1 + `BRAM_LAT` + N.
- With defaults: L1=806, L2=42, L3=32, so the last `io_we` is at edge 880, `done` at edge 881, and IDLE at edge 882.
- `busy` is high for edges 1..880 inclusive.
- Layer boundary: the cycle after the final WB write already presents `WEIGHT_{k+1}` with `mac_clr`=1, with no bubble.
- `mac_en` and `io_we` are never high in the same cycle. The last `bias_en` strictly precedes the first `io_we` of that layer.

## Test plan
- Reset then idle 10 cycles → all outputs 0; `start` pulse → at edge 1 `rd_addr`=0x000, `mac_clr`=1, `busy`=1.
- Full run, BRAM_LAT=1 → exactly 784/20/20 `mac_en` cycles and one `bias_en` per layer, with `bias_en` at `rd_addr`=0x310/0x325/0x33a delayed 1. Writes land at 0x311–0x324, 0x326–0x339, 0x33b–0x344. `done` pulses once, at edge 881.
- Full run, BRAM_LAT=3 → `mac_en` lags addresses by 3; total latency grows by 6; same address sets.
- `start` re-pulsed at edges 5 and 400 → ignored; single `done`; `start` on the `done` cycle also ignored; `start` 1 cycle after `done` begins a new run.
- `reset_n` asserted mid-layer-2 (e.g. edge 820) → outputs 0 immediately without a clock edge. After release, `start` gives a clean full run starting from 0x000.
- `relu_en` is high during all L1/L2 write-back cycles and low during all 10 L3 writes; `wr_sel` sequence is 0..19, 0..19, 0..9.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: control FSM that runs a three-layer fully-connected MNIST inference over shared BRAM ports.
package bram_addrs;
    localparam int WEIGHT_1   = 'h000;
    localparam int BIAS_1     = 'h310;
    localparam int LAYER_IO_1 = 'h311;
    localparam int WEIGHT_2   = 'h311;
    localparam int BIAS_2     = 'h325;
    localparam int LAYER_IO_2 = 'h326;
    localparam int WEIGHT_3   = 'h326;
    localparam int BIAS_3     = 'h33a;
    localparam int LAYER_IO_3 = 'h33b;
endpackage

module nn_layer_sequencer
    import bram_addrs::*;
#(
    parameter int ADDR_W   = 10,
    parameter int N_HID    = 20,
    parameter int N_OUT    = 10,
    parameter int BRAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              bias_en,
    output logic              relu_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [4:0]        wr_sel,
    output logic              io_we,
    output logic [1:0]        layer,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, MAC, BIAS, DRAIN, WB, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t              state, state_d;
    logic [4:0]          cnt, cnt_d, wr_sel_d;
    logic [ADDR_W-1:0]   rd_addr_d, wr_addr_d;
    logic [1:0]          layer_d;
    logic                mac_clr_d, io_we_d, busy_d, done_d;
    logic [BRAM_LAT-1:0] mac_sr, bias_sr;

    function automatic logic [ADDR_W-1:0] weight_of(input logic [1:0] k);
        return ADDR_W'(k == 2'd1 ? WEIGHT_1 : k == 2'd2 ? WEIGHT_2 : WEIGHT_3);
    endfunction

    function automatic logic [ADDR_W-1:0] bias_of(input logic [1:0] k);
        return ADDR_W'(k == 2'd1 ? BIAS_1 : k == 2'd2 ? BIAS_2 : BIAS_3);
    endfunction

    function automatic logic [ADDR_W-1:0] io_of(input logic [1:0] k);
        return ADDR_W'(k == 2'd1 ? LAYER_IO_1 : k == 2'd2 ? LAYER_IO_2 : LAYER_IO_3);
    endfunction

    function automatic logic [4:0] last_of(input logic [1:0] k);
        return 5'(k == 2'd3 ? N_OUT - 1 : N_HID - 1);
    endfunction

    // Next-state and next-output decode; every output is registered from these values
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        rd_addr_d = rd_addr;
        layer_d   = layer;
        busy_d    = busy;
        mac_clr_d = 1'b0;
        io_we_d   = 1'b0;
        wr_sel_d  = '0;
        wr_addr_d = '0;
        done_d    = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_d   = MAC;
                layer_d   = 2'd1;
                rd_addr_d = weight_of(2'd1);
                mac_clr_d = 1'b1;
                busy_d    = 1'b1;
            end
            MAC: begin
                state_d   = rd_addr == bias_of(layer) - ONE ? BIAS : MAC;
                rd_addr_d = rd_addr + ONE;
            end
            BIAS: begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            DRAIN: if (cnt == 5'(BRAM_LAT - 1)) begin
                state_d   = WB;
                cnt_d     = '0;
                io_we_d   = 1'b1;
                wr_addr_d = io_of(layer);
            end else begin
                cnt_d = cnt + 5'd1;
            end
            WB: if (cnt != last_of(layer)) begin
                cnt_d     = cnt + 5'd1;
                io_we_d   = 1'b1;
                wr_sel_d  = cnt + 5'd1;
                wr_addr_d = io_of(layer) + ADDR_W'(cnt + 5'd1);
            end else if (layer == 2'd3) begin
                state_d   = DONE;
                layer_d   = '0;
                rd_addr_d = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
            end else begin
                state_d   = MAC;
                layer_d   = layer + 2'd1;
                rd_addr_d = weight_of(layer + 2'd1);
                mac_clr_d = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_addr <= '0;
            layer   <= '0;
            busy    <= 1'b0;
            mac_clr <= 1'b0;
            io_we   <= 1'b0;
            wr_sel  <= '0;
            wr_addr <= '0;
            done    <= 1'b0;
            relu_en <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            rd_addr <= rd_addr_d;
            layer   <= layer_d;
            busy    <= busy_d;
            mac_clr <= mac_clr_d;
            io_we   <= io_we_d;
            wr_sel  <= wr_sel_d;
            wr_addr <= wr_addr_d;
            done    <= done_d;
            relu_en <= layer_d == 2'd1 || layer_d == 2'd2;
        end
    end

    // Delay the MAC/BIAS flags by the BRAM read latency so enables meet the returned data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac_sr  <= '0;
            bias_sr <= '0;
        end else begin
            mac_sr[0]  <= state == MAC;
            bias_sr[0] <= state == BIAS;
            for (int i = 1; i < BRAM_LAT; i++) begin
                mac_sr[i]  <= mac_sr[i-1];
                bias_sr[i] <= bias_sr[i-1];
            end
        end
    end

    assign mac_en  = mac_sr[BRAM_LAT-1];
    assign bias_en = bias_sr[BRAM_LAT-1];
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: randomized bench comparing two latency variants against a timeline model.
module tb_nn_layer_sequencer;
    localparam int NIN[3]  = '{784, 20, 20};
    localparam int NN[3]   = '{20, 20, 10};
    localparam int BASE[3] = '{'h000, 'h311, 'h326};
    localparam int BIAS[3] = '{'h310, 'h325, 'h33a};
    localparam int IO[3]   = '{'h311, 'h326, 'h33b};

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic start = 1'b0;
    int checks = 0;
    int errs = 0;
    int rt1 = 0;
    int rt3 = 0;

    logic [9:0] rd_addr1, wr_addr1, rd_addr3, wr_addr3;
    logic [4:0] wr_sel1, wr_sel3;
    logic [1:0] layer1, layer3;
    logic mac_clr1, mac_en1, bias_en1, relu_en1, io_we1, busy1, done1;
    logic mac_clr3, mac_en3, bias_en3, relu_en3, io_we3, busy3, done3;
    logic [33:0] v1, v3;

    always #5 clk = ~clk;

    nn_layer_sequencer #(.BRAM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .rd_addr(rd_addr1), .mac_clr(mac_clr1),
        .mac_en(mac_en1), .bias_en(bias_en1), .relu_en(relu_en1), .wr_addr(wr_addr1),
        .wr_sel(wr_sel1), .io_we(io_we1), .layer(layer1), .busy(busy1), .done(done1));

    nn_layer_sequencer #(.BRAM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start), .rd_addr(rd_addr3), .mac_clr(mac_clr3),
        .mac_en(mac_en3), .bias_en(bias_en3), .relu_en(relu_en3), .wr_addr(wr_addr3),
        .wr_sel(wr_sel3), .io_we(io_we3), .layer(layer3), .busy(busy3), .done(done3));

    assign v1 = {busy1, layer1, rd_addr1, mac_clr1, mac_en1, bias_en1, relu_en1, io_we1, wr_addr1, wr_sel1, done1};
    assign v3 = {busy3, layer3, rd_addr3, mac_clr3, mac_en3, bias_en3, relu_en3, io_we3, wr_addr3, wr_sel3, done3};

    function automatic int total(int lat);
        int t = 0;
        for (int k = 0; k < 3; k++) t += NIN[k] + 1 + lat + NN[k];
        return t;
    endfunction

    function automatic int locate(int lat, int rt, output int o);
        o = rt - 1;
        for (int k = 0; k < 3; k++) begin
            if (o < NIN[k] + 1 + lat + NN[k]) return k;
            o -= NIN[k] + 1 + lat + NN[k];
        end
        return -1;
    endfunction

    function automatic int kind(int lat, int rt);
        int o, k;
        if (rt < 1 || rt > total(lat)) return 0;
        k = locate(lat, rt, o);
        return o < NIN[k] ? 1 : o == NIN[k] ? 2 : 0;
    endfunction

    function automatic logic [33:0] expv(int lat, int rt);
        int o, k, n;
        logic [33:0] v;
        v = '0;
        if (rt >= 1 && rt <= total(lat)) begin
            k = locate(lat, rt, o);
            v[33] = 1'b1;
            v[32:31] = 2'(k + 1);
            v[17] = k < 2;
            if (o < NIN[k]) begin
                v[30:21] = 10'(BASE[k] + o);
                v[20] = o == 0;
            end else if (o <= NIN[k] + lat) begin
                v[30:21] = 10'(BIAS[k]);
            end else begin
                n = o - NIN[k] - 1 - lat;
                v[16] = 1'b1;
                v[15:6] = 10'(IO[k] + n);
                v[5:1] = 5'(n);
            end
        end
        v[0] = rt == total(lat) + 1;
        v[19] = kind(lat, rt - lat) == 1;
        v[18] = kind(lat, rt - lat) == 2;
        return v;
    endfunction

    function automatic logic [33:0] care(int lat, int rt);
        logic [33:0] m, e;
        m = '1;
        e = expv(lat, rt);
        if (rt == total(lat) + 1 || e[16]) m[30:21] = '0;
        if (e[33] && !e[16]) m[15:1] = '0;
        return m;
    endfunction

    function automatic int nxt(int rt, int lat, logic st);
        return rt == 0 ? int'(st) : rt == total(lat) + 1 ? 0 : rt + 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rt1 <= 0;
            rt3 <= 0;
        end else begin
            rt1 <= nxt(rt1, 1, start);
            rt3 <= nxt(rt3, 3, start);
        end
    end

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (v1 !== '0 || v3 !== '0) begin
            errs++;
            $display("FAIL reset_async: got %h/%h want 0", v1, v3);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (v1 !== '0 || v3 !== '0) begin
                errs++;
                $display("FAIL reset_idle cycle %0d: got %h/%h want 0", i, v1, v3);
            end
        end
    endtask

    task automatic test_writeback();
        int mac_n[4] = '{default: 0};
        int done_n = 0, done_e1 = 0, done_e3 = 0, first1 = 0, first3 = 0, overlap = 0;
        logic [9:0] prev_rd = '0;
        logic [9:0] bq[$];
        logic [9:0] wa[$];
        logic [4:0] ws[$];
        logic rl[$];
        logic [9:0] bias_exp[3] = '{10'h310, 10'h325, 10'h33a};
        int mac_exp[3] = '{784, 20, 20};
        logic [15:0] got, want;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 1; e <= 900; e++) begin
            @(negedge clk);
            if (e == 1) begin
                checks++;
                if ({busy1, layer1, rd_addr1, mac_clr1} !== {1'b1, 2'd1, 10'h000, 1'b1}) begin
                    errs++;
                    $display("FAIL first_edge: got busy=%b layer=%0d rd=%h clr=%b want 1 1 000 1", busy1, layer1, rd_addr1, mac_clr1);
                end
            end
            if (mac_en1) mac_n[layer1]++;
            if (bias_en1) bq.push_back(prev_rd);
            if (io_we1) begin
                wa.push_back(wr_addr1);
                ws.push_back(wr_sel1);
                rl.push_back(relu_en1);
                if (mac_en1) overlap++;
            end
            if (done1) begin
                done_n++;
                done_e1 = e;
            end
            if (done3) done_e3 = e;
            if (mac_en1 && first1 == 0) first1 = e;
            if (mac_en3 && first3 == 0) first3 = e;
            prev_rd = rd_addr1;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mac_n[k+1] != mac_exp[k]) begin
                errs++;
                $display("FAIL mac_count L%0d: got %0d want %0d", k + 1, mac_n[k+1], mac_exp[k]);
            end
            checks++;
            if (bq.size() != 3 || bq[k] !== bias_exp[k]) begin
                errs++;
                $display("FAIL bias_addr L%0d: got %0d entries want 3, addr %h", k + 1, bq.size(), bias_exp[k]);
            end
        end
        for (int i = 0; i < 50; i++) begin
            want = i < 20 ? {10'(12'h311 + i), 5'(i), 1'b1} :
                   i < 40 ? {10'(12'h326 + i - 20), 5'(i - 20), 1'b1} :
                            {10'(12'h33b + i - 40), 5'(i - 40), 1'b0};
            got = i < wa.size() ? {wa[i], ws[i], rl[i]} : 16'hffff;
            checks++;
            if (got !== want) begin
                errs++;
                $display("FAIL write %0d: got addr/sel/relu %h want %h", i, got, want);
            end
        end
        checks++;
        if (wa.size() != 50) begin
            errs++;
            $display("FAIL write_count: got %0d want 50", wa.size());
        end
        checks++;
        if (done_n != 1 || done_e1 != 881) begin
            errs++;
            $display("FAIL done_lat1: got %0d pulses at edge %0d want 1 at 881", done_n, done_e1);
        end
        checks++;
        if (done_e3 != 887) begin
            errs++;
            $display("FAIL done_lat3: got edge %0d want 887", done_e3);
        end
        checks++;
        if (first1 != 2 || first3 != 4) begin
            errs++;
            $display("FAIL first_mac_en: got %0d/%0d want 2/4", first1, first3);
        end
        checks++;
        if (overlap != 0) begin
            errs++;
            $display("FAIL mac_io_overlap: got %0d want 0", overlap);
        end
    endtask

    task automatic test_run(input string name, input int p0, p1, p2, p3, input int rst_at, input int len);
        logic [33:0] m;
        for (int c = 0; c < len; c++) begin
            start = c == p0 || c == p1 || c == p2 || c == p3;
            @(posedge clk);
            @(negedge clk);
            m = care(1, rt1);
            checks++;
            if ((v1 & m) !== (expv(1, rt1) & m)) begin
                errs++;
                $display("FAIL %s lat1 step %0d rt %0d: got %h want %h", name, c, rt1, v1 & m, expv(1, rt1) & m);
            end
            m = care(3, rt3);
            checks++;
            if ((v3 & m) !== (expv(3, rt3) & m)) begin
                errs++;
                $display("FAIL %s lat3 step %0d rt %0d: got %h want %h", name, c, rt3, v3 & m, expv(3, rt3) & m);
            end
            if (c == rst_at) begin
                start = 1'b0;
                #2 reset_n = 1'b0;
                #1;
                checks++;
                if (v1 !== '0 || v3 !== '0) begin
                    errs++;
                    $display("FAIL %s async_reset: got %h/%h want 0", name, v1, v3);
                end
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        start = 1'b0;
        checks++;
        if (rt1 != 0 || rt3 != 0) begin
            errs++;
            $display("FAIL %s timeout: got rt %0d/%0d want idle", name, rt1, rt3);
        end
    endtask

    initial begin
        int g, r;
        test_reset();
        test_writeback();
        g = $urandom_range(0, 20);
        test_run("reissue", g, g + 5, g + 400, g + $urandom_range(600, 870), -1, 1000);
        test_run("done_edge", 0, 882, 883, -1, -1, 1800);
        r = $urandom_range(812, 845);
        test_run("reset_mid", 0, $urandom_range(100, 700), r + 5, -1, r, r + 900);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
